// File: rtl/ifid_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and BOOT/RUN/WAIT fetch FSM.
// Optional fetch-stall performance counter is enabled by defining IFID_PERF_CNT_EN.
module ifid_fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PC_stall_i,
    input  logic        IFID_stall_i,
    input  logic        Flush_i,
    input  logic [31:0] Branch_target_i,
    output logic        Imem_req_o,
    output logic [31:0] Imem_addr_o,
    input  logic [31:0] Imem_data_i,
    input  logic        Imem_ready_i,
    output logic [31:0] IFID_instr_o,
    output logic [31:0] IFID_pc4_o,
    output logic        IFID_valid_o,
    output logic [15:0] Stall_cnt_o,
    output logic [1:0]  fsm_state_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        flush_eff;
    logic        fetch_ok;

    // A branch in ID is unresolved while IF/ID is stalled, so its flush is dropped.
    assign flush_eff = Flush_i && !IFID_stall_i;
    assign fetch_ok  = (state != BOOT) && Imem_ready_i;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        pc_next = pc;
        if (PC_stall_i) begin
            pc_next = pc;
        end else if (flush_eff) begin
            pc_next = Branch_target_i;
        end else if (fetch_ok) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= BOOT;
            Imem_req_o   <= 1'b0;
            pc           <= 32'h0000_0000;
            IFID_instr_o <= 32'h0000_0000;
            IFID_pc4_o   <= 32'h0000_0000;
            IFID_valid_o <= 1'b0;
        end else begin
            Imem_req_o <= 1'b1;
            pc         <= pc_next;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (Imem_req_o && !Imem_ready_i && !PC_stall_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (Imem_ready_i || flush_eff) begin
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
            // Bubbles keep the previous pc4; only instr and valid are cleared.
            if (!IFID_stall_i) begin
                if (flush_eff || !fetch_ok) begin
                    IFID_instr_o <= 32'h0000_0000;
                    IFID_valid_o <= 1'b0;
                end else begin
                    IFID_instr_o <= Imem_data_i;
                    IFID_pc4_o   <= pc_plus4;
                    IFID_valid_o <= 1'b1;
                end
            end
        end
    end

    assign Imem_addr_o = pc;
    assign fsm_state_o = state;

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic        stall_event;

    assign stall_event = (state != BOOT) && (IFID_stall_i || flush_eff || !Imem_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= 16'd0;
        end else if (stall_event && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign Stall_cnt_o = stall_cnt;
`else
    assign Stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Directed self-checking bench for ifid_fetch_stage; inputs change 1ns after each
// rising edge and outputs are checked there, well away from the next edge.
module tb_ifid_fetch_stage;

    logic        clk;
    logic        rst;
    logic        pc_stall;
    logic        ifid_stall;
    logic        flush;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
    logic [1:0]  st;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IFID_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    ifid_fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .PC_stall_i      (pc_stall),
        .IFID_stall_i    (ifid_stall),
        .Flush_i         (flush),
        .Branch_target_i (target),
        .Imem_req_o      (req),
        .Imem_addr_o     (addr),
        .Imem_data_i     (data),
        .Imem_ready_i    (ready),
        .IFID_instr_o    (instr),
        .IFID_pc4_o      (pc4),
        .IFID_valid_o    (valid),
        .Stall_cnt_o     (cnt),
        .fsm_state_o     (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_ON ? n : 32'd0;
    endfunction

    task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid);
        chk({tag, "_instr"}, instr, e_instr);
        chk({tag, "_pc4"}, pc4, e_pc4);
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, e_valid});
    endtask

    initial begin
        rst = 1'b1; pc_stall = 1'b0; ifid_stall = 1'b0; flush = 1'b0;
        target = 32'h0; data = 32'h0; ready = 1'b1;
        step();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_state", {30'd0, st}, {30'd0, S_BOOT});
        chk("rst_cnt", {16'd0, cnt}, 32'd0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);

        // Sequential fetch: BOOT cycle is a bubble, then 0, 4, 8.
        rst = 1'b0; data = 32'h2008_0001;
        step();
        chk("boot_req", {31'd0, req}, 32'd1);
        chk("boot_state", {30'd0, st}, {30'd0, S_RUN});
        chk("boot_addr", addr, 32'h0);
        chk("boot_valid", {31'd0, valid}, 32'd0);
        step();
        chk("seq1_addr", addr, 32'h4);
        chk_ifid("seq1", 32'h2008_0001, 32'h4, 1'b1);
        data = 32'h2009_0002;
        step();
        chk("seq2_addr", addr, 32'h8);
        chk_ifid("seq2", 32'h2009_0002, 32'h8, 1'b1);

        // Both stalls held for two cycles.
        pc_stall = 1'b1; ifid_stall = 1'b1; data = 32'h1111_1111;
        step();
        step();
        chk("stall_addr", addr, 32'h8);
        chk_ifid("stall", 32'h2009_0002, 32'h8, 1'b1);
        chk("stall_cnt", {16'd0, cnt}, exp_cnt(2));
        pc_stall = 1'b0; ifid_stall = 1'b0; data = 32'h2222_2222;
        step();
        chk("resume_addr", addr, 32'hC);
        chk_ifid("resume", 32'h2222_2222, 32'hC, 1'b1);

        // Taken branch.
        flush = 1'b1; target = 32'h40; data = 32'hDEAD_BEEF;
        step();
        chk("flush_addr", addr, 32'h40);
        chk("flush_instr", instr, 32'h0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        flush = 1'b0; data = 32'h3333_3333;
        step();
        chk("tgt_addr", addr, 32'h44);
        chk_ifid("tgt", 32'h3333_3333, 32'h44, 1'b1);

        // Flush under full stall is dropped.
        flush = 1'b1; target = 32'h80; pc_stall = 1'b1; ifid_stall = 1'b1; data = 32'h4444_4444;
        step();
        chk("flstall_addr", addr, 32'h44);
        chk_ifid("flstall", 32'h3333_3333, 32'h44, 1'b1);
        chk("flstall_cnt", {16'd0, cnt}, exp_cnt(4));

        // Redirect to 0x10, then memory not ready for 3 cycles.
        pc_stall = 1'b0; ifid_stall = 1'b0; target = 32'h10;
        step();
        chk("to10_addr", addr, 32'h10);
        flush = 1'b0; ready = 1'b0; data = 32'hBAD0_BAD0;
        step();
        step();
        step();
        chk("wait_state", {30'd0, st}, {30'd0, S_WAIT});
        chk("wait_addr", addr, 32'h10);
        chk("wait_req", {31'd0, req}, 32'd1);
        chk("wait_instr", instr, 32'h0);
        chk("wait_valid", {31'd0, valid}, 32'd0);
        chk("wait_cnt", {16'd0, cnt}, exp_cnt(8));

        // Reset during WAIT, with flush and stalls also asserted.
        rst = 1'b1; flush = 1'b1; target = 32'h99; pc_stall = 1'b1; ifid_stall = 1'b1;
        step();
        chk("wrst_addr", addr, 32'h0);
        chk("wrst_state", {30'd0, st}, {30'd0, S_BOOT});
        chk("wrst_req", {31'd0, req}, 32'd0);
        chk("wrst_cnt", {16'd0, cnt}, 32'd0);
        chk_ifid("wrst", 32'h0, 32'h0, 1'b0);

        // PC+4 wraps at the top of the address space.
        rst = 1'b0; flush = 1'b0; pc_stall = 1'b0; ifid_stall = 1'b0; ready = 1'b1;
        step();
        flush = 1'b1; target = 32'hFFFF_FFFC;
        step();
        chk("wrap_addr0", addr, 32'hFFFF_FFFC);
        flush = 1'b0; data = 32'hABCD_0123;
        step();
        chk("wrap_addr1", addr, 32'h0);
        chk_ifid("wrap", 32'hABCD_0123, 32'h0, 1'b1);

        // Flush in WAIT abandons the pending fetch.
        ready = 1'b0;
        step();
        chk("w2_state", {30'd0, st}, {30'd0, S_WAIT});
        flush = 1'b1; target = 32'h200;
        step();
        chk("wflush_state", {30'd0, st}, {30'd0, S_RUN});
        chk("wflush_addr", addr, 32'h200);
        chk("wflush_valid", {31'd0, valid}, 32'd0);
        flush = 1'b0; ready = 1'b1; data = 32'h5555_5555;
        step();
        chk("after_addr", addr, 32'h204);
        chk_ifid("after", 32'h5555_5555, 32'h204, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
